prbs_pkt_checker: RTL and testbench
===================================

PRBS_PKT_CHECKER -- requirements
Module: prbs_pkt_checker

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32: receive data width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have the parameter VLDB_W, default DATA_W/16: width of the valid-lane mask, one bit per 16-bit lane.
REQ-003 The block SHALL have the parameter PKT_BEATS, default 256: expected packet length in beats, in the range 2..65535.
REQ-004 The block SHALL have the parameter POLY_LENGTH, default 31: PRBS register length.
REQ-005 The block SHALL have the parameter POLY_TAP, default 28: second feedback tap.
REQ-006 The block SHALL have the parameter INV_PATTERN, default 1: when 1, received data is inverted before checking.
REQ-007 The block SHALL have the parameter LOCK_BEATS, default 8: number of consecutive error-free beats needed to lock.
REQ-008 The block SHALL have the parameter UNLOCK_ERRS, default 4: number of consecutive errored beats that causes loss of lock.
REQ-009 The block SHALL have the parameter CNT_W, default 16: width of every statistics counter.
REQ-010 The block SHALL have these ports, clock and reset first:
 - rx_user_clk_i, in, 1: the only clock.
 - rx_user_rst_i, in, 1: reset, asynchronous, active-high.
 - rx_data_i, in, DATA_W: beat data.
 - rx_vldb_i, in, VLDB_W: lane-valid mask.
 - rx_valid_i, in, 1: beat qualifier.
 - rx_last_i, in, 1: last beat of a packet.
 - clr_i, in, 1: synchronous clear of all counters.
 - lock_o, out, 1: PRBS checker is locked.
 - err_o, out, 1: sticky error summary.
 - len_err_cnt_o, out, CNT_W: length-error count.
 - vldb_err_cnt_o, out, CNT_W: lane-mask error count.
 - bit_err_cnt_o, out, CNT_W: bit-error count.
 - pkt_cnt_o, out, CNT_W: count of received packets.

Function
REQ-011 Beats SHALL be processed only when rx_valid_i=1; all other inputs SHALL be ignored on cycles with rx_valid_i=0.
REQ-012 The checker SHALL be self-synchronising: expected bit i = d[i-POLY_LENGTH] XOR d[i-POLY_TAP], taken over the serial stream with bit 0 of each beat first, using the previous POLY_LENGTH received bits as history.
REQ-013 Per-beat mismatch data SHALL be registered one cycle after the valid beat; the counters and the state machine SHALL update on the following edge, giving 2-cycle latency from beat to counter.
REQ-014 The state machine SHALL have three states: HUNT (reset state), CHECK, LOCKED.
REQ-015 From HUNT, the first valid beat SHALL load the history without producing a compare and SHALL move to CHECK.
REQ-016 In CHECK, LOCK_BEATS consecutive zero-mismatch beats SHALL move to LOCKED, and any mismatch SHALL restart the run count.
REQ-017 In LOCKED, UNLOCK_ERRS consecutive errored beats SHALL move to HUNT, and a clean beat SHALL zero that consecutive count.
REQ-018 lock_o SHALL be 1 only in LOCKED.
REQ-019 bit_err_cnt_o SHALL add the popcount of the mismatch vector only while in LOCKED, including the beat that triggers the move to HUNT.
REQ-020 The beat counter SHALL zero on rx_last_i and otherwise increment by 1.
REQ-021 A long-packet length error SHALL be counted when the beat at index PKT_BEATS-1 has no rx_last_i; the beat counter SHALL then wrap to 0.
REQ-022 A short-packet length error SHALL be counted when rx_last_i arrives at an index below PKT_BEATS-1.
REQ-023 pkt_cnt_o SHALL increment on every beat with rx_last_i=1, whatever its length.
REQ-024 vldb_err_cnt_o SHALL increment on every valid beat where rx_vldb_i is not all-ones.
REQ-025 All counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 When clr_i=1, all counters and err_o SHALL clear; clr_i SHALL win over a simultaneous increment; clr_i SHALL NOT affect the state machine, the PRBS history or the beat counter.
REQ-027 err_o SHALL be set by any length, lane-mask or bit error, or by loss of lock out of LOCKED, and SHALL remain set until clr_i or reset.

Reset
REQ-028 Asserting rx_user_rst_i SHALL immediately force HUNT, and SHALL zero the history, beat counter, all counters, lock_o and err_o, including mid-packet.
REQ-029 After reset is released, the first beat SHALL be treated as beat index 0.

Verification
REQ-030 Clean PRBS31 stream, DATA_W=32, packets of 256 beats -> lock_o=1 by beat 10; after 4 packets, pkt_cnt_o=4 and every error counter=0, err_o=0.
REQ-031 While locked, flip 3 bits in one beat -> bit_err_cnt_o=3 two cycles later, err_o=1, lock_o stays 1.
REQ-032 Corrupt 4 consecutive beats -> lock_o=0; after clean data, relock within LOCK_BEATS+1 beats, with no bit counting before relock.
REQ-033 Packet with rx_last_i at beat 100 -> len_err_cnt_o=1; 300-beat packet -> a further len_err at beat 255, and pkt_cnt_o counts 1 for it.
REQ-034 rx_vldb_i=2'b01 on 2 beats -> vldb_err_cnt_o=2; CNT_W=4 with 20 forced errors -> counter holds 15; clr_i in the same cycle as an error -> counter=0.
REQ-035 Assert reset mid-packet, locked -> all outputs 0 asynchronously, before the next clock edge; after release -> HUNT, and the next beat is index 0.

Source files
------------

// File: rtl/prbs_pkt_checker.sv
// Self-synchronising PRBS checker with packet-length, lane-mask and bit-error
// statistics. Beats are compared in one stage and accounted for in the next.
module prbs_pkt_checker #(
    parameter int DATA_W      = 32,
    parameter int VLDB_W      = DATA_W / 16,
    parameter int PKT_BEATS   = 256,
    parameter int POLY_LENGTH = 31,
    parameter int POLY_TAP    = 28,
    parameter int INV_PATTERN = 1,
    parameter int LOCK_BEATS  = 8,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic              rx_user_clk_i,
    input  logic              rx_user_rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic [VLDB_W-1:0] rx_vldb_i,
    input  logic              rx_valid_i,
    input  logic              rx_last_i,
    input  logic              clr_i,
    output logic              lock_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  len_err_cnt_o,
    output logic [CNT_W-1:0]  vldb_err_cnt_o,
    output logic [CNT_W-1:0]  bit_err_cnt_o,
    output logic [CNT_W-1:0]  pkt_cnt_o
);

    localparam int BEAT_W = $clog2(PKT_BEATS);
    localparam int RUN_W  = $clog2(LOCK_BEATS + 1);
    localparam int ERR_W  = $clog2(UNLOCK_ERRS + 1);
    localparam int PC_W   = $clog2(DATA_W + 1);
    localparam int EXT_W  = POLY_LENGTH + DATA_W;
    localparam int SUM_W  = CNT_W + 8;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_t;

    state_t state_q, state_d;

    logic [POLY_LENGTH-1:0] hist_q;
    logic [BEAT_W-1:0]      beatCnt_q;
    logic                   s1Valid_q;
    logic [DATA_W-1:0]      s1Mism_q;
    logic                   s1LenErr_q;
    logic                   s1VldbErr_q;
    logic                   s1Last_q;
    logic [RUN_W-1:0]       run_q, run_d;
    logic [ERR_W-1:0]       errRun_q, errRun_d;
    logic [CNT_W-1:0]       lenErrCnt_q, lenErrCnt_d;
    logic [CNT_W-1:0]       vldbErrCnt_q, vldbErrCnt_d;
    logic [CNT_W-1:0]       bitErrCnt_q, bitErrCnt_d;
    logic [CNT_W-1:0]       pktCnt_q, pktCnt_d;
    logic                   err_q, err_d;

    logic [DATA_W-1:0] rxBits;
    logic [EXT_W-1:0]  ext;
    logic [DATA_W-1:0] mism;
    logic              atEnd;
    logic [PC_W-1:0]   popCnt;
    logic              bitErrHit;
    logic              lossOfLock;
    logic [SUM_W-1:0]  bitSum;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + CNT_W'(1) : v;
    endfunction

    // The newest received bits sit above the history, so each expected bit is
    // the XOR of the bits POLY_LENGTH and POLY_TAP positions earlier in ext.
    assign rxBits = (INV_PATTERN != 0) ? ~rx_data_i : rx_data_i;
    assign ext    = {rxBits, hist_q};
    assign atEnd  = (beatCnt_q == BEAT_W'(PKT_BEATS - 1));

    always_comb begin
        mism = '0;
        for (int i = 0; i < DATA_W; i++) begin
            mism[i] = rxBits[i] ^ ext[i] ^ ext[i + POLY_LENGTH - POLY_TAP];
        end
    end

    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i) begin
            hist_q      <= '0;
            beatCnt_q   <= '0;
            s1Valid_q   <= 1'b0;
            s1Mism_q    <= '0;
            s1LenErr_q  <= 1'b0;
            s1VldbErr_q <= 1'b0;
            s1Last_q    <= 1'b0;
        end else begin
            s1Valid_q <= rx_valid_i;
            if (rx_valid_i) begin
                hist_q      <= ext[EXT_W-1 -: POLY_LENGTH];
                beatCnt_q   <= (rx_last_i || atEnd) ? '0 : beatCnt_q + BEAT_W'(1);
                s1Mism_q    <= mism;
                s1LenErr_q  <= rx_last_i ^ atEnd;
                s1VldbErr_q <= ~&rx_vldb_i;
                s1Last_q    <= rx_last_i;
            end
        end
    end

    always_comb begin
        popCnt = '0;
        for (int i = 0; i < DATA_W; i++) begin
            popCnt = popCnt + PC_W'(s1Mism_q[i]);
        end
    end

    // Lock state machine; it consumes the registered per-beat mismatch vector.
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        errRun_d   = errRun_q;
        bitErrHit  = 1'b0;
        lossOfLock = 1'b0;
        if (s1Valid_q) begin
            case (state_q)
                HUNT: begin
                    state_d = CHECK;
                    run_d   = '0;
                end
                CHECK: begin
                    if (popCnt != '0) begin
                        run_d = '0;
                    end else if (run_q == RUN_W'(LOCK_BEATS - 1)) begin
                        state_d  = LOCKED;
                        run_d    = '0;
                        errRun_d = '0;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    if (popCnt == '0) begin
                        errRun_d = '0;
                    end else begin
                        bitErrHit = 1'b1;
                        if (errRun_q == ERR_W'(UNLOCK_ERRS - 1)) begin
                            state_d    = HUNT;
                            errRun_d   = '0;
                            lossOfLock = 1'b1;
                        end else begin
                            errRun_d = errRun_q + ERR_W'(1);
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        bitSum       = SUM_W'(bitErrCnt_q) + SUM_W'(popCnt);
        lenErrCnt_d  = satInc(lenErrCnt_q, s1Valid_q & s1LenErr_q);
        vldbErrCnt_d = satInc(vldbErrCnt_q, s1Valid_q & s1VldbErr_q);
        pktCnt_d     = satInc(pktCnt_q, s1Valid_q & s1Last_q);
        bitErrCnt_d  = bitErrCnt_q;
        if (bitErrHit) begin
            bitErrCnt_d = (bitSum > SUM_W'({CNT_W{1'b1}})) ? '1 : bitSum[CNT_W-1:0];
        end
        err_d = err_q | bitErrHit | lossOfLock | (s1Valid_q & (s1LenErr_q | s1VldbErr_q));
        if (clr_i) begin
            lenErrCnt_d  = '0;
            vldbErrCnt_d = '0;
            bitErrCnt_d  = '0;
            pktCnt_d     = '0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge rx_user_clk_i or posedge rx_user_rst_i) begin
        if (rx_user_rst_i) begin
            state_q      <= HUNT;
            run_q        <= '0;
            errRun_q     <= '0;
            lenErrCnt_q  <= '0;
            vldbErrCnt_q <= '0;
            bitErrCnt_q  <= '0;
            pktCnt_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            errRun_q     <= errRun_d;
            lenErrCnt_q  <= lenErrCnt_d;
            vldbErrCnt_q <= vldbErrCnt_d;
            bitErrCnt_q  <= bitErrCnt_d;
            pktCnt_q     <= pktCnt_d;
            err_q        <= err_d;
        end
    end

    assign lock_o         = (state_q == LOCKED);
    assign err_o          = err_q;
    assign len_err_cnt_o  = lenErrCnt_q;
    assign vldb_err_cnt_o = vldbErrCnt_q;
    assign bit_err_cnt_o  = bitErrCnt_q;
    assign pkt_cnt_o      = pktCnt_q;

endmodule

// File: tb/tb_prbs_pkt_checker.sv
// Randomized bench for prbs_pkt_checker: a serial-stream reference model with a
// one-beat accounting delay, checked against a default and a 4-bit-counter DUT.
module tb_prbs_pkt_checker;

    localparam int DATA_W      = 32;
    localparam int VLDB_W      = 2;
    localparam int PKT_BEATS   = 256;
    localparam int POLY_LENGTH = 31;
    localparam int POLY_TAP    = 28;
    localparam int LOCK_BEATS  = 8;
    localparam int UNLOCK_ERRS = 4;
    localparam int CNT_W       = 16;
    localparam int SMALL_W     = 4;
    localparam int TAP_IDX     = POLY_LENGTH - POLY_TAP;

    localparam int AUTO_LAST  = 0;
    localparam int FORCE_LAST = 1;
    localparam int NO_LAST    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] rxData;
    logic [VLDB_W-1:0] rxVldb;
    logic              rxValid;
    logic              rxLast;
    logic              clr;

    logic               lock, err;
    logic [CNT_W-1:0]   lenCnt, vldbCnt, bitCnt, pktCnt;
    logic               lockS, errS;
    logic [SMALL_W-1:0] lenCntS, vldbCntS, bitCntS, pktCntS;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs_pkt_checker u_dut (
        .rx_user_clk_i (clk),
        .rx_user_rst_i (rst),
        .rx_data_i     (rxData),
        .rx_vldb_i     (rxVldb),
        .rx_valid_i    (rxValid),
        .rx_last_i     (rxLast),
        .clr_i         (clr),
        .lock_o        (lock),
        .err_o         (err),
        .len_err_cnt_o (lenCnt),
        .vldb_err_cnt_o(vldbCnt),
        .bit_err_cnt_o (bitCnt),
        .pkt_cnt_o     (pktCnt)
    );

    prbs_pkt_checker #(.CNT_W(SMALL_W)) u_small (
        .rx_user_clk_i (clk),
        .rx_user_rst_i (rst),
        .rx_data_i     (rxData),
        .rx_vldb_i     (rxVldb),
        .rx_valid_i    (rxValid),
        .rx_last_i     (rxLast),
        .clr_i         (clr),
        .lock_o        (lockS),
        .err_o         (errS),
        .len_err_cnt_o (lenCntS),
        .vldb_err_cnt_o(vldbCntS),
        .bit_err_cnt_o (bitCntS),
        .pkt_cnt_o     (pktCntS)
    );

    // Reference model: the received serial stream and per-beat statistics.
    bit genHist[$];
    bit rxHist[$];
    int txIdx;
    int mBeatIdx;
    bit mHunting, mLocked;
    int mClean, mErrRun;
    int mPkt, mLen, mVldb, mBit;
    bit mErr;
    bit pValid, pLast, pLen, pVldb;
    int pPop;

    function automatic int satv(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic modelReset();
        rxHist.delete();
        for (int i = 0; i < POLY_LENGTH; i++) rxHist.push_back(1'b0);
        mBeatIdx = 0;
        mHunting = 1'b1;
        mLocked  = 1'b0;
        mClean   = 0;
        mErrRun  = 0;
        mPkt = 0; mLen = 0; mVldb = 0; mBit = 0;
        mErr   = 1'b0;
        pValid = 1'b0;
        txIdx  = 0;
    endtask

    // Accounts for the beat received one cycle earlier, then applies a clear.
    task automatic modelApply(input bit clrNow);
        if (pValid) begin
            if (mLocked) begin
                if (pPop > 0) begin
                    mBit += pPop;
                    mErr = 1'b1;
                    mErrRun++;
                    if (mErrRun == UNLOCK_ERRS) begin
                        mLocked  = 1'b0;
                        mHunting = 1'b1;
                        mErrRun  = 0;
                    end
                end else begin
                    mErrRun = 0;
                end
            end else if (mHunting) begin
                mHunting = 1'b0;
                mClean   = 0;
            end else if (pPop == 0) begin
                mClean++;
                if (mClean == LOCK_BEATS) begin
                    mLocked = 1'b1;
                    mClean  = 0;
                    mErrRun = 0;
                end
            end else begin
                mClean = 0;
            end
            if (pLen)  begin mLen++;  mErr = 1'b1; end
            if (pVldb) begin mVldb++; mErr = 1'b1; end
            if (pLast) mPkt++;
        end
        if (clrNow) begin
            mPkt = 0; mLen = 0; mVldb = 0; mBit = 0;
            mErr = 1'b0;
        end
    endtask

    task automatic modelBeat(input logic [DATA_W-1:0] data, input logic [VLDB_W-1:0] vldb, input bit last);
        logic [DATA_W-1:0] r;
        int pop;
        bit atEnd;
        r   = ~data;
        pop = 0;
        for (int i = 0; i < DATA_W; i++) begin
            bit e;
            e = rxHist[0] ^ rxHist[TAP_IDX];
            if (r[i] != e) pop++;
            rxHist.push_back(r[i]);
            void'(rxHist.pop_front());
        end
        atEnd    = (mBeatIdx == PKT_BEATS - 1);
        pValid   = 1'b1;
        pPop     = pop;
        pLast    = last;
        pLen     = (last && !atEnd) || (!last && atEnd);
        pVldb    = (vldb != '1);
        mBeatIdx = (last || atEnd) ? 0 : mBeatIdx + 1;
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic [VLDB_W-1:0] vldb,
                                 input bit valid, input bit last, input bit clrNow);
        @(negedge clk);
        rxData  = data;
        rxVldb  = vldb;
        rxValid = valid;
        rxLast  = last;
        clr     = clrNow;
        modelApply(clrNow);
        if (valid) modelBeat(data, vldb, last);
        else       pValid = 1'b0;
    endtask

    task automatic idle(input int n, input bit clrNow);
        for (int i = 0; i < n; i++) applyStimulus($urandom, $urandom, 1'b0, $urandom, clrNow);
    endtask

    task automatic getWord(output logic [DATA_W-1:0] w);
        for (int i = 0; i < DATA_W; i++) begin
            bit b;
            b = genHist[0] ^ genHist[TAP_IDX];
            w[i] = b;
            genHist.push_back(b);
            void'(genHist.pop_front());
        end
    endtask

    // Next PRBS word, optionally corrupted, framed into PKT_BEATS packets by default.
    task automatic sendBeat(input logic [DATA_W-1:0] flip, input logic [VLDB_W-1:0] vldb, input int lastMode);
        logic [DATA_W-1:0] w;
        bit last;
        getWord(w);
        if (lastMode == FORCE_LAST)   last = 1'b1;
        else if (lastMode == NO_LAST) last = 1'b0;
        else                          last = (txIdx == PKT_BEATS - 1);
        txIdx = (last || txIdx == PKT_BEATS - 1) ? 0 : txIdx + 1;
        applyStimulus(~w ^ flip, vldb, 1'b1, last, 1'b0);
    endtask

    task automatic checkAll(input string tag);
        @(posedge clk);
        #1;
        checkOutput({tag, ".lock"},  lock,    mLocked);
        checkOutput({tag, ".err"},   err,     mErr);
        checkOutput({tag, ".len"},   lenCnt,  satv(mLen, CNT_W));
        checkOutput({tag, ".vldb"},  vldbCnt, satv(mVldb, CNT_W));
        checkOutput({tag, ".bit"},   bitCnt,  satv(mBit, CNT_W));
        checkOutput({tag, ".pkt"},   pktCnt,  satv(mPkt, CNT_W));
        checkOutput({tag, ".lockS"}, lockS,   mLocked);
        checkOutput({tag, ".errS"},  errS,    mErr);
        checkOutput({tag, ".lenS"},  lenCntS, satv(mLen, SMALL_W));
        checkOutput({tag, ".vldbS"}, vldbCntS, satv(mVldb, SMALL_W));
        checkOutput({tag, ".bitS"},  bitCntS, satv(mBit, SMALL_W));
        checkOutput({tag, ".pktS"},  pktCntS, satv(mPkt, SMALL_W));
    endtask

    initial begin
        logic [DATA_W-1:0] flip;
        int savedBit;
        int p0, p1, p2;

        rst = 1'b1; rxData = '0; rxVldb = '1; rxValid = 1'b0; rxLast = 1'b0; clr = 1'b0;
        for (int i = 0; i < POLY_LENGTH; i++) genHist.push_back(bit'($urandom_range(0, 1)));
        genHist[0] = 1'b1;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkAll("reset");

        // Clean stream: four full packets, lock reached by the tenth beat.
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < PKT_BEATS; b++) begin
                sendBeat('0, '1, AUTO_LAST);
                if (p == 0 && b == 9) begin
                    checkAll("lock10");
                    checkOutput("lockBy10", lock, 1);
                end
            end
        end
        idle(2, 1'b0);
        checkAll("clean4");
        checkOutput("clean.pkt", pktCnt, 4);
        checkOutput("clean.bit", bitCnt, 0);
        checkOutput("clean.err", err, 0);

        // Three flipped bits in one locked beat appear two cycles later.
        idle(1, 1'b1);
        repeat (4) sendBeat('0, '1, AUTO_LAST);
        p0 = $urandom_range(4, 31);
        do p1 = $urandom_range(4, 31); while (p1 == p0);
        do p2 = $urandom_range(4, 31); while (p2 == p0 || p2 == p1);
        flip = '0;
        flip[p0] = 1'b1; flip[p1] = 1'b1; flip[p2] = 1'b1;
        sendBeat(flip, '1, AUTO_LAST);
        checkAll("flip1");
        checkOutput("flip.early", bitCnt, 0);
        idle(1, 1'b0);
        checkAll("flip2");
        checkOutput("flip.bit3", bitCnt, 3);
        checkOutput("flip.err", err, 1);
        checkOutput("flip.lock", lock, 1);
        repeat (6) sendBeat('0, '1, AUTO_LAST);
        checkAll("flipAfter");

        // Four corrupted beats drop lock; relock takes LOCK_BEATS+1 clean beats.
        repeat (UNLOCK_ERRS) sendBeat($urandom, '1, AUTO_LAST);
        idle(2, 1'b0);
        checkAll("unlock");
        checkOutput("unlock.lock", lock, 0);
        savedBit = mBit;
        repeat (LOCK_BEATS) sendBeat('0, '1, AUTO_LAST);
        idle(2, 1'b0);
        checkAll("relock8");
        checkOutput("relock8.lock", lock, 0);
        checkOutput("relock8.bit", bitCnt, savedBit);
        sendBeat('0, '1, AUTO_LAST);
        idle(2, 1'b0);
        checkAll("relock9");
        checkOutput("relock9.lock", lock, 1);

        // Asynchronous reset mid-packet while locked.
        repeat (5) sendBeat('0, '1, AUTO_LAST);
        checkAll("preReset");
        @(negedge clk);
        rxValid = 1'b0;
        clr     = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst.lock", lock, 0);
        checkOutput("arst.err", err, 0);
        checkOutput("arst.bit", bitCnt, 0);
        checkOutput("arst.len", lenCnt, 0);
        checkOutput("arst.pkt", pktCnt, 0);
        checkOutput("arst.vldb", vldbCnt, 0);
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Short packet (last at index 100), then a 300-beat packet.
        for (int b = 0; b <= 100; b++) sendBeat('0, '1, (b == 100) ? FORCE_LAST : NO_LAST);
        idle(2, 1'b0);
        checkAll("short");
        checkOutput("short.len", lenCnt, 1);
        checkOutput("short.pkt", pktCnt, 1);
        for (int b = 0; b < 300; b++) begin
            sendBeat('0, '1, (b == 299) ? FORCE_LAST : NO_LAST);
            if (b == PKT_BEATS - 1) begin
                idle(2, 1'b0);
                checkAll("long255");
                checkOutput("long.len", lenCnt, 2);
            end
        end
        idle(2, 1'b0);
        checkAll("long300");
        checkOutput("long.pkt", pktCnt, 2);

        // Lane-mask errors, saturation of the 4-bit instance, clear beating increment.
        idle(1, 1'b1);
        repeat (2) sendBeat('0, 2'b01, AUTO_LAST);
        idle(2, 1'b0);
        checkAll("vldb2");
        checkOutput("vldb.two", vldbCnt, 2);
        repeat (20) sendBeat('0, VLDB_W'($urandom_range(0, 2)), AUTO_LAST);
        idle(2, 1'b0);
        checkAll("vldbSat");
        checkOutput("vldb.big22", vldbCnt, 22);
        checkOutput("vldb.sat15", vldbCntS, 15);
        sendBeat('0, 2'b10, AUTO_LAST);
        idle(1, 1'b1);
        checkAll("clrWins");
        checkOutput("clrWins.vldb", vldbCnt, 0);
        checkOutput("clrWins.vldbS", vldbCntS, 0);

        // Randomized traffic.
        for (int it = 0; it < 3000; it++) begin
            int r;
            logic [DATA_W-1:0] fl;
            logic [VLDB_W-1:0] vl;
            int lm;
            r = $urandom_range(0, 99);
            if (r < 18) begin
                idle(1, 1'b0);
            end else if (r < 19) begin
                idle(1, 1'b1);
            end else if (r < 20) begin
                repeat (5) sendBeat($urandom, '1, AUTO_LAST);
            end else begin
                fl = '0;
                if ($urandom_range(0, 99) < 6) fl[$urandom_range(0, DATA_W - 1)] = 1'b1;
                if ($urandom_range(0, 99) < 2) fl = $urandom;
                vl = ($urandom_range(0, 99) < 5) ? VLDB_W'($urandom_range(0, 2)) : '1;
                lm = $urandom_range(0, 99);
                lm = (lm < 3) ? FORCE_LAST : (lm < 5) ? NO_LAST : AUTO_LAST;
                sendBeat(fl, vl, lm);
            end
            if (it % 16 == 15) checkAll("rand");
        end
        idle(3, 1'b0);
        checkAll("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
